fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 clock  in  1  sole clock; all state updates on posedge clock.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 stall  in  1  hazard unit holds the PC and the IF/ID contents.
REQ-005 redirect  in  1  branch/jump taken; refetch from redirect_pc.
REQ-006 redirect_pc  in  32  target address; bits [1:0] ignored, treated as 00.
REQ-007 imem_req  out  1  instruction memory request valid.
REQ-008 imem_addr  out  32  request address, equals pc.
REQ-009 imem_ready  in  1  memory accepts the request this cycle.
REQ-010 imem_rvalid  in  1  read data returned this cycle.
REQ-011 imem_rdata  in  32  returned instruction word.
REQ-012 Inst  out  32  instruction presented to the IF/ID register.
REQ-013 PC_Plus4  out  32  fetch address + 4 for Inst.
REQ-014 IFIDWrite  out  1  IF/ID register loads Inst/PC_Plus4.
REQ-015 flush  out  1  IF/ID register loads zero (NOP bubble).

Function
REQ-016 FSM states: REQ (drive request), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-017 In REQ, imem_req=1 only when the one-entry fetch buffer is empty or is being consumed this cycle; a request is accepted when imem_req && imem_ready, then REQ->WAIT.
REQ-018 At most one request is outstanding at any time.
REQ-019 In WAIT, an imem_rvalid loads buffer {Inst=imem_rdata, PC_Plus4=pc+4}, sets buf_valid, advances pc by 4, and returns to REQ.
REQ-020 PC arithmetic is modulo 2^32; pc=32'hFFFF_FFFC yields PC_Plus4=0 and next pc 0.
REQ-021 IFIDWrite = buf_valid && !stall && !redirect; a buffer entry is consumed exactly when IFIDWrite=1.
REQ-022 flush = redirect || (!buf_valid && !stall); IFIDWrite and flush are never both 1.
REQ-023 stall=1 (no redirect): IFIDWrite=0, flush=0, buffer and pc held; outstanding responses still capture into an empty buffer.
REQ-024 redirect=1 wins over stall: flush=1, buffer cleared, pc<=redirect_pc & ~3 next cycle.
REQ-025 redirect in REQ with no accept, or with accept same cycle: state DROP if a request is left outstanding, else REQ; the new address is issued no earlier than the next cycle.
REQ-026 redirect in WAIT without rvalid: WAIT->DROP; with rvalid same cycle: data discarded, ->REQ.
REQ-027 In DROP, imem_req=0; imem_rvalid data is discarded (buffer untouched), then DROP->REQ.
REQ-028 redirect in DROP updates the pending pc only; state stays DROP.
REQ-029 Best-case throughput with 1-cycle memory and no stall: one instruction per 2 cycles; Inst valid to IF/ID the cycle after rvalid.

Reset
REQ-030 While reset_n=0 at posedge: pc<=RESET_PC, state<=REQ, buf_valid<=0, Inst<=0, PC_Plus4<=0.
REQ-031 While reset_n=0: imem_req=0, IFIDWrite=0, flush=1.
REQ-032 Reset mid-request abandons the outstanding response; memory must not return rvalid for it after reset release (bench guarantees).

Structure
REQ-033 Shared package cpu_pkg holds NOP_INST=32'h0, the FSM state encoding and the default RESET_PC.
REQ-034 One sub-module fetch_buf: one-entry {Inst, PC_Plus4, valid} register with load, consume and clear ports.
REQ-035 No latches; all outputs except IFIDWrite, flush, imem_req and imem_addr are registered.

Verification
REQ-036 Reset release, 1-cycle memory returning 32'h2002_0005 at addr 0 -> imem_addr=0, next IFIDWrite=1 with Inst=32'h2002_0005, PC_Plus4=4.
REQ-037 stall held 3 cycles while buffer holds addr 8 instruction -> IFIDWrite=0, flush=0 for 3 cycles, pc stays 12, same Inst after release.
REQ-038 redirect to 32'h0000_0043 while WAIT at addr 16 -> flush=1, response for 16 discarded, next imem_addr=32'h0000_0040.
REQ-039 stall and redirect same cycle -> flush=1, IFIDWrite=0, fetch resumes at the redirect target.
REQ-040 pc=32'hFFFF_FFFC fetch -> PC_Plus4=0, next imem_addr=0.
REQ-041 reset_n low for one cycle during WAIT -> next cycle pc=RESET_PC, buf_valid=0, flush=1, no stale Inst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: NOP encoding, fetch FSM states, reset PC.
package cpu_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // REQ: drive request, WAIT: one request outstanding, DROP: discard response
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; low two bits are ignored
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry fetch buffer holding {Inst, PC_Plus4, valid} between memory and IF/ID.
module fetch_buf
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n_i,
    input  logic        load_i,
    input  logic        consume_i,
    input  logic        clear_i,
    input  logic [31:0] load_inst_i,
    input  logic [31:0] load_pc_plus4_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] inst_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;

    // Clear beats load beats consume; data is zeroed on reset and clear so no stale word survives
    always_ff @(posedge clock) begin
        if (!reset_n_i) begin
            inst_q     <= NOP_INST;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (clear_i) begin
            inst_q     <= NOP_INST;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            inst_q     <= load_inst_i;
            pc_plus4_q <= load_pc_plus4_i;
            valid_q    <= 1'b1;
        end else if (consume_i) begin
            valid_q    <= 1'b0;
        end
    end

    assign inst_o     = inst_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests, one-entry buffer,
// stall/redirect handling toward the IF/ID pipeline register.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] PC_Plus4,
    output logic        IFIDWrite,
    output logic        flush
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         buf_valid;
    logic         accept;
    logic         buf_load;

    // Handshake and IF/ID controls; reset forces a bubble and no request
    always_comb begin
        IFIDWrite = reset_n && buf_valid && !stall && !redirect;
        flush     = !reset_n || redirect || (!buf_valid && !stall);
        imem_req  = reset_n && (state_q == ST_REQ) && (!buf_valid || IFIDWrite);
        imem_addr = pc_q;
        accept    = imem_req && imem_ready;
        buf_load  = (state_q == ST_WAIT) && imem_rvalid && !redirect;
    end

    // Next state and pc; pc only advances when a response is kept, redirect overrides it
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_REQ: begin
                if (accept) state_d = redirect ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                    if (!redirect) pc_d = pc_q + 32'd4;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
        if (redirect) pc_d = word_align(redirect_pc);
    end

    // FSM and pc registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buf u_fetch_buf (
        .clock           (clock),
        .reset_n_i       (reset_n),
        .load_i          (buf_load),
        .consume_i       (IFIDWrite),
        .clear_i         (redirect),
        .load_inst_i     (imem_rdata),
        .load_pc_plus4_i (pc_q + 32'd4),
        .inst_o          (Inst),
        .pc_plus4_o      (PC_Plus4),
        .valid_o         (buf_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized stall/redirect/reset traffic,
// checked by a program-order stream scoreboard and a memory model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Inst;
    logic [31:0] PC_Plus4;
    logic        IFIDWrite;
    logic        flush;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Inst        (Inst),
        .PC_Plus4    (PC_Plus4),
        .IFIDWrite   (IFIDWrite),
        .flush       (flush)
    );

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Expected program-order fetch addresses still to be delivered to IF/ID
    logic [31:0] exp_q[$];
    logic [31:0] last_pushed;

    // Memory model state
    bit          mem_pending  = 1'b0;
    logic [31:0] mem_addr_q   = '0;
    int unsigned mem_lat_cnt  = 0;
    int unsigned lat_min      = 1;
    int unsigned lat_max      = 1;
    int unsigned ready_pct    = 100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2002_0005;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic restart_stream(input logic [31:0] a);
        exp_q.delete();
        exp_q.push_back(a);
        last_pushed = a;
    endtask

    task automatic top_up();
        while (exp_q.size() < 32) begin
            last_pushed = last_pushed + 32'd4;
            exp_q.push_back(last_pushed);
        end
    endtask

    // Drive one cycle of inputs just after the clock edge and update the stream model
    task automatic step(input logic rst_n, input logic st, input logic rd, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        reset_n     = rst_n;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (!rst_n)  restart_stream(RST_PC);
        else if (rd) restart_stream(rpc & ~32'h3);
        top_up();
        #2;
    endtask

    // Memory response driver: answers an accepted request after its latency
    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clock);
            #1;
            imem_ready = ($urandom_range(99) < ready_pct);
            if (mem_pending && mem_lat_cnt == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr_q);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            if (mem_pending && mem_lat_cnt > 1) mem_lat_cnt--;
        end
    end

    // Memory request acceptor: records accepted requests, abandons them on reset
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mem_pending = 1'b0;
            end else begin
                if (imem_rvalid) mem_pending = 1'b0;
                if (imem_req && imem_ready) begin
                    chk("single_outstanding", {31'd0, mem_pending}, 32'd0);
                    chk("req_aligned", imem_addr & 32'h3, 32'd0);
                    mem_pending = 1'b1;
                    mem_addr_q  = imem_addr;
                    mem_lat_cnt = $urandom_range(lat_max, lat_min);
                end
            end
        end
    end

    // Monitor: pops expected entries on every IF/ID write and checks control rules
    initial begin
        int unsigned idle = 0;
        logic [31:0] a;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                idle = 0;
                chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
                chk("rst_ifidwrite", {31'd0, IFIDWrite}, 32'd0);
                chk("rst_flush", {31'd0, flush}, 32'd1);
            end else begin
                chk("write_flush_exclusive", {31'd0, IFIDWrite & flush}, 32'd0);
                if (redirect) begin
                    chk("redirect_flush", {31'd0, flush}, 32'd1);
                    chk("redirect_no_write", {31'd0, IFIDWrite}, 32'd0);
                end else if (stall) begin
                    chk("stall_no_write", {31'd0, IFIDWrite}, 32'd0);
                    chk("stall_no_flush", {31'd0, flush}, 32'd0);
                end
                if (IFIDWrite) begin
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_delivery", 32'd1, 32'd0);
                    end else begin
                        a = exp_q.pop_front();
                        chk("sb_inst", Inst, mem_word(a));
                        chk("sb_pc_plus4", PC_Plus4, a + 32'd4);
                    end
                end else begin
                    idle++;
                    if (idle > 300) begin
                        chk("progress_timeout", idle, 32'd0);
                        idle = 0;
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic [31:0] rpc;
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        restart_stream(RST_PC);
        top_up();
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);

        // Reset release with 1-cycle memory
        step(1'b1, 1'b0, 1'b0, '0);                          // R0
        chk("r0_req", {31'd0, imem_req}, 32'd1);
        chk("r0_addr", imem_addr, RST_PC);
        chk("r0_flush", {31'd0, flush}, 32'd1);
        chk("r0_no_write", {31'd0, IFIDWrite}, 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);                          // R1
        chk("r1_no_write", {31'd0, IFIDWrite}, 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);                          // R2
        chk("first_write", {31'd0, IFIDWrite}, 32'd1);
        chk("first_inst", Inst, 32'h2002_0005);
        chk("first_pc_plus4", PC_Plus4, 32'd4);
        step(1'b1, 1'b0, 1'b0, '0);                          // R3
        step(1'b1, 1'b0, 1'b0, '0);                          // R4
        chk("second_write", {31'd0, IFIDWrite}, 32'd1);
        chk("second_pc_plus4", PC_Plus4, 32'd8);

        // Stall while the buffer holds the addr 8 instruction
        step(1'b1, 1'b1, 1'b0, '0);                          // R5
        for (int i = 0; i < 3; i++) begin                    // R6..R8
            step(1'b1, 1'b1, 1'b0, '0);
            chk("stall_write", {31'd0, IFIDWrite}, 32'd0);
            chk("stall_flush", {31'd0, flush}, 32'd0);
            chk("stall_pc", imem_addr, 32'd12);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_inst", Inst, mem_word(32'd8));
        end
        step(1'b1, 1'b0, 1'b0, '0);                          // R9
        chk("unstall_write", {31'd0, IFIDWrite}, 32'd1);
        chk("unstall_inst", Inst, mem_word(32'd8));
        step(1'b1, 1'b0, 1'b0, '0);                          // R10
        lat_min = 2; lat_max = 2;
        step(1'b1, 1'b0, 1'b0, '0);                          // R11
        chk("addr16_req", imem_addr, 32'd16);
        chk("addr12_pc_plus4", PC_Plus4, 32'd16);

        // Redirect while waiting on addr 16
        step(1'b1, 1'b0, 1'b1, 32'h0000_0043);               // R12
        lat_min = 1; lat_max = 1;
        chk("wait_no_req", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);                          // R13
        chk("drop_no_req", {31'd0, imem_req}, 32'd0);
        chk("drop_no_write", {31'd0, IFIDWrite}, 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);                          // R14
        chk("redirect_addr", imem_addr, 32'h0000_0040);
        chk("redirect_req", {31'd0, imem_req}, 32'd1);
        step(1'b1, 1'b0, 1'b0, '0);                          // R15
        step(1'b1, 1'b0, 1'b0, '0);                          // R16
        chk("target_inst", Inst, mem_word(32'h40));
        step(1'b1, 1'b0, 1'b0, '0);                          // R17

        // Stall and redirect in the same cycle
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);               // R18
        chk("stall_redir_req", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);                          // R19
        chk("resume_addr", imem_addr, 32'h0000_0100);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_no_write", {31'd0, IFIDWrite}, 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);                          // R20

        // Wraparound at the top of the address space
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);               // R21
        step(1'b1, 1'b0, 1'b0, '0);                          // R22
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, '0);                          // R23
        lat_min = 2; lat_max = 2;
        step(1'b1, 1'b0, 1'b0, '0);                          // R24
        chk("wrap_write", {31'd0, IFIDWrite}, 32'd1);
        chk("wrap_pc_plus4", PC_Plus4, 32'd0);
        chk("wrap_next_addr", imem_addr, 32'd0);

        // One-cycle reset during WAIT
        step(1'b0, 1'b0, 1'b0, '0);                          // R25
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b0, 1'b0, '0);                          // R26
        chk("post_rst_addr", imem_addr, RST_PC);
        chk("post_rst_inst", Inst, 32'd0);
        chk("post_rst_pc_plus4", PC_Plus4, 32'd0);
        chk("post_rst_flush", {31'd0, flush}, 32'd1);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);

        // Randomized traffic
        lat_min = 1; lat_max = 4; ready_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(($urandom_range(999) < 5) ? 1'b0 : 1'b1,
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 5),
                 rpc);
        end
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
